// File: rtl/elevator_pkg.sv
// Shared floor, direction and state codes for the four-stop elevator scheduler.
package elevator_pkg;

  localparam int unsigned FLOOR_W    = 2;
  localparam int unsigned DIR_W      = 2;
  localparam int unsigned NUM_FLOORS = 4;

  typedef enum logic [FLOOR_W-1:0] {
    FLOOR_M1 = 2'b00,
    FLOOR_1  = 2'b01,
    FLOOR_2  = 2'b10,
    FLOOR_3  = 2'b11
  } floor_e;

  typedef enum logic [DIR_W-1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_MOVING     = 2'b01,
    ST_DOORS_OPEN = 2'b10
  } state_e;

  // One-hot mask of a single floor index.
  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
    return 4'b0001 << f;
  endfunction

  // Floors strictly above f.
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [FLOOR_W-1:0] f);
    return 4'hF << (3'(f) + 3'd1);
  endfunction

  // Floors strictly below f.
  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [FLOOR_W-1:0] f);
    return ~(4'hF << f);
  endfunction

endpackage

// File: rtl/elevator_tick_counter.sv
// Shared move/dwell timer: counts 0..term, done_c high on the last cycle, then wraps.
module elevator_tick_counter #(
  parameter int unsigned CTR_W = 34
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CTR_W-1:0] term,
  output logic             done_c
);

  logic [CTR_W-1:0] cnt;

  assign done_c = (cnt == term);

  // Count up, returning to zero on terminal count or while held clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || done_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CTR_W'(1);
    end
  end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN call scheduler: latches calls, picks direction/next stop, times moves and door dwell.
module elevator_scheduler #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned DOOR_CYCLES = 100000000,
  parameter int unsigned CTR_W       = 34
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] call_req,
  output logic [1:0] piso,
  output logic [1:0] direccion,
  output logic       puertas_abiertas,
  output logic [3:0] pending,
  output logic       busy
);

  import elevator_pkg::*;

  localparam logic [CTR_W-1:0] MOVE_TERM = CTR_W'(TICK_DIV - 1);
  localparam logic [CTR_W-1:0] DOOR_TERM = CTR_W'(DOOR_CYCLES - 1);

  state_e           state;
  logic [3:0]       above;
  logic [3:0]       below;
  logic [3:0]       ahead;
  logic [3:0]       behind;
  logic [3:0]       clear_mask;
  logic [1:0]       next_floor;
  logic             open_idle;
  logic             arrive;
  logic             ctr_clr;
  logic [CTR_W-1:0] term;
  logic             done_c;

  // Shared timer; held at zero in IDLE so every MOVING/DOORS_OPEN entry starts from 0.
  elevator_tick_counter #(.CTR_W(CTR_W)) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (ctr_clr),
    .term   (term),
    .done_c (done_c)
  );

  // Request geometry relative to the current floor, and the floor-bit to clear this edge.
  always_comb begin
    above  = pending & above_mask(piso);
    below  = pending & below_mask(piso);
    ahead  = above;
    behind = below;
    if (direccion == DIR_DOWN) begin
      ahead  = below;
      behind = above;
    end

    next_floor = piso;
    if (direccion == DIR_UP && piso != FLOOR_3) begin
      next_floor = piso + 2'd1;
    end else if (direccion == DIR_DOWN && piso != FLOOR_M1) begin
      next_floor = piso - 2'd1;
    end

    open_idle = (state == ST_IDLE) && pending[piso];
    arrive    = (state == ST_MOVING) && done_c && pending[next_floor];

    // Calls for the open floor are absorbed for the whole dwell.
    clear_mask = '0;
    if (state == ST_DOORS_OPEN || open_idle) begin
      clear_mask = floor_bit(piso);
    end else if (arrive) begin
      clear_mask = floor_bit(next_floor);
    end

    term    = (state == ST_DOORS_OPEN) ? DOOR_TERM : MOVE_TERM;
    ctr_clr = (state == ST_IDLE);
  end

  // Scheduler FSM with registered floor, direction, door, pending and busy outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      piso             <= FLOOR_1;
      direccion        <= DIR_IDLE;
      puertas_abiertas <= 1'b0;
      pending          <= '0;
      busy             <= 1'b0;
    end else begin
      pending <= (pending | call_req) & ~clear_mask;
      case (state)
        ST_IDLE: begin
          if (open_idle) begin
            state            <= ST_DOORS_OPEN;
            puertas_abiertas <= 1'b1;
            direccion        <= DIR_IDLE;
            busy             <= 1'b1;
          end else if (|above) begin
            state     <= ST_MOVING;
            direccion <= DIR_UP;
            busy      <= 1'b1;
          end else if (|below) begin
            state     <= ST_MOVING;
            direccion <= DIR_DOWN;
            busy      <= 1'b1;
          end
        end
        ST_MOVING: begin
          if (done_c) begin
            piso <= next_floor;
            if (arrive) begin
              state            <= ST_DOORS_OPEN;
              puertas_abiertas <= 1'b1;
            end
          end
        end
        ST_DOORS_OPEN: begin
          if (done_c) begin
            puertas_abiertas <= 1'b0;
            if (|ahead) begin
              state     <= ST_MOVING;
              direccion <= (direccion == DIR_DOWN) ? DIR_DOWN : DIR_UP;
            end else if (|behind) begin
              state     <= ST_MOVING;
              direccion <= (direccion == DIR_DOWN) ? DIR_UP : DIR_DOWN;
            end else begin
              state     <= ST_IDLE;
              direccion <= DIR_IDLE;
              busy      <= 1'b0;
            end
          end
        end
        default: begin
          state            <= ST_IDLE;
          direccion        <= DIR_IDLE;
          puertas_abiertas <= 1'b0;
          busy             <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench: reference model pushes expected output changes, a monitor pops and compares.
module tb_elevator_scheduler;

  localparam int unsigned TICK_DIV    = 4;
  localparam int unsigned DOOR_CYCLES = 6;
  localparam int unsigned CTR_W       = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] call_req;
  logic [1:0] piso;
  logic [1:0] direccion;
  logic       puertas_abiertas;
  logic [3:0] pending;
  logic       busy;

  elevator_scheduler #(
    .TICK_DIV    (TICK_DIV),
    .DOOR_CYCLES (DOOR_CYCLES),
    .CTR_W       (CTR_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .call_req         (call_req),
    .piso             (piso),
    .direccion        (direccion),
    .puertas_abiertas (puertas_abiertas),
    .pending          (pending),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] piso;
    logic [1:0] dir;
    logic       doors;
    logic [3:0] pend;
    logic       busy;
  } snap_t;

  snap_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    g_edge   = 0;
  bit    mon_en   = 1'b0;
  snap_t mon_last;
  snap_t model_last;

  // Reference model: floor index 0..3, direction +1/-1/0, mode 0 idle / 1 moving / 2 doors.
  int       m_floor;
  int       m_dir;
  int       m_mode;
  int       m_cnt;
  bit [3:0] m_pend;

  function automatic bit same(input snap_t a, input snap_t b);
    return a.piso == b.piso && a.dir == b.dir && a.doors == b.doors &&
           a.pend == b.pend && a.busy == b.busy;
  endfunction

  function automatic snap_t model_snap();
    snap_t s;
    s.cyc   = 0;
    s.piso  = 2'(m_floor);
    s.dir   = (m_dir == 1) ? 2'b01 : (m_dir == -1) ? 2'b10 : 2'b00;
    s.doors = (m_mode == 2);
    s.pend  = m_pend;
    s.busy  = (m_mode != 0);
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.cyc   = g_edge;
    s.piso  = piso;
    s.dir   = direccion;
    s.doors = puertas_abiertas;
    s.pend  = pending;
    s.busy  = busy;
    return s;
  endfunction

  // True if any pending call lies strictly beyond floor f walking in direction d.
  function automatic bit any_toward(input int f, input int d);
    for (int k = f + d; k >= 0 && k <= 3; k += d)
      if (m_pend[k]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push_if_changed(input int tag);
    snap_t s;
    s = model_snap();
    s.cyc = tag;
    if (!same(s, model_last)) begin
      exp_q.push_back(s);
      model_last = s;
    end
  endtask

  task automatic model_reset(input int tag);
    m_floor = 1; m_dir = 0; m_mode = 0; m_cnt = 0; m_pend = '0;
    push_if_changed(tag);
  endtask

  // One clock edge of the collective-control rules.
  task automatic model_step(input logic [3:0] c);
    bit [3:0] np;
    int d;
    np = m_pend | c;
    case (m_mode)
      0: begin
        if (m_pend[m_floor]) begin
          m_mode = 2; m_dir = 0; m_cnt = 0; np[m_floor] = 1'b0;
        end else if (any_toward(m_floor, 1)) begin
          m_mode = 1; m_dir = 1; m_cnt = 0;
        end else if (any_toward(m_floor, -1)) begin
          m_mode = 1; m_dir = -1; m_cnt = 0;
        end
      end
      1: begin
        if (m_cnt == TICK_DIV - 1) begin
          m_cnt = 0;
          if (m_floor + m_dir >= 0 && m_floor + m_dir <= 3) m_floor = m_floor + m_dir;
          if (m_pend[m_floor]) begin
            m_mode = 2; np[m_floor] = 1'b0;
          end
        end else begin
          m_cnt++;
        end
      end
      default: begin
        np[m_floor] = 1'b0;
        if (m_cnt == DOOR_CYCLES - 1) begin
          m_cnt = 0;
          d = (m_dir == 0) ? 1 : m_dir;
          if (any_toward(m_floor, d)) begin
            m_mode = 1; m_dir = d;
          end else if (any_toward(m_floor, -d)) begin
            m_mode = 1; m_dir = -d;
          end else begin
            m_mode = 0; m_dir = 0;
          end
        end else begin
          m_cnt++;
        end
      end
    endcase
    m_pend = np;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, g_edge);
    end
  endtask

  // Monitor: every change of DUT outputs must match the next expected change, on the right edge.
  always @(negedge clk) begin
    if (mon_en) begin
      snap_t d;
      snap_t e;
      d = dut_snap();
      while (exp_q.size() > 0 && exp_q[0].cyc < g_edge) begin
        e = exp_q.pop_front();
        n_checks++;
        n_errors++;
        $display("FAIL missed_change: expected piso=%0d dir=%0d doors=%0b pend=%b busy=%0b at edge %0d, got piso=%0d dir=%0d doors=%0b pend=%b busy=%0b",
                 e.piso, e.dir, e.doors, e.pend, e.busy, e.cyc, d.piso, d.dir, d.doors, d.pend, d.busy);
      end
      if (!same(d, mon_last)) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_change: got piso=%0d dir=%0d doors=%0b pend=%b busy=%0b at edge %0d, expected no change",
                   d.piso, d.dir, d.doors, d.pend, d.busy, g_edge);
        end else begin
          e = exp_q.pop_front();
          if (!same(d, e) || e.cyc != g_edge) begin
            n_errors++;
            $display("FAIL output_change: got piso=%0d dir=%0d doors=%0b pend=%b busy=%0b at edge %0d, expected piso=%0d dir=%0d doors=%0b pend=%b busy=%0b at edge %0d",
                     d.piso, d.dir, d.doors, d.pend, d.busy, g_edge, e.piso, e.dir, e.doors, e.pend, e.busy, e.cyc);
          end
        end
      end
      mon_last = d;
    end
  end

  // One clock: present calls at the falling edge, step the model on the rising edge.
  task automatic cycle(input logic [3:0] c);
    @(negedge clk);
    call_req = c;
    @(posedge clk);
    g_edge++;
    model_step(c);
    push_if_changed(g_edge);
    #1;
  endtask

  // Assert reset asynchronously mid-cycle, check outputs at once, release between edges.
  task automatic do_reset();
    @(negedge clk);
    #1;
    call_req = 4'b0000;
    rst_n = 1'b0;
    model_reset(g_edge + 1);
    #1;
    chk("async_reset", int'({piso, direccion, puertas_abiertas, pending, busy}),
        int'({2'b01, 2'b00, 1'b0, 4'b0000, 1'b0}));
    repeat (3) begin
      @(posedge clk);
      g_edge++;
    end
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] c;
    rst_n    = 1'b0;
    call_req = 4'b0000;
    m_floor = 1; m_dir = 0; m_mode = 0; m_cnt = 0; m_pend = '0;
    model_last = model_snap();
    repeat (3) begin
      @(posedge clk);
      g_edge++;
    end
    #2;
    chk("reset_state", int'({piso, direccion, puertas_abiertas, pending, busy}),
        int'({2'b01, 2'b00, 1'b0, 4'b0000, 1'b0}));
    mon_last = dut_snap();
    mon_en   = 1'b1;
    rst_n    = 1'b1;

    // 1: idle with no calls
    for (int e = 0; e < 50; e++) begin
      cycle(4'b0000);
      if (e % 10 == 9)
        chk("s1_idle", int'({piso, direccion, puertas_abiertas, pending, busy}),
            int'({2'b01, 2'b00, 1'b0, 4'b0000, 1'b0}));
    end

    // 2: single call to top floor
    do_reset();
    cycle(4'b1000);
    chk("s2_pend_e0", int'(pending), 8);
    for (int e = 1; e <= 15; e++) begin
      cycle(4'b0000);
      if (e == 1) chk("s2_up_e1", int'({direccion, busy}), int'({2'b01, 1'b1}));
      if (e == 5) chk("s2_piso_e5", int'(piso), 2);
      if (e == 9) chk("s2_arrive_e9", int'({piso, puertas_abiertas, pending}), int'({2'b11, 1'b1, 4'b0000}));
      if (e == 15) chk("s2_close_e15", int'({puertas_abiertas, direccion, busy}), int'({1'b0, 2'b00, 1'b0}));
    end

    // 3: call for current floor
    do_reset();
    cycle(4'b0010);
    for (int e = 1; e <= 7; e++) begin
      cycle(4'b0000);
      if (e == 1) chk("s3_open_e1", int'({piso, puertas_abiertas}), int'({2'b01, 1'b1}));
      if (e == 7) chk("s3_close_e7", int'(puertas_abiertas), 0);
    end

    // 4: intermediate stop added during travel
    do_reset();
    for (int e = 0; e <= 30; e++) begin
      cycle((e == 0) ? 4'b1000 : (e == 3) ? 4'b0100 : 4'b0000);
      if (e == 5) chk("s4_stop_e5", int'({piso, puertas_abiertas, pending}), int'({2'b10, 1'b1, 4'b1000}));
      if (e == 15) chk("s4_top_e15", int'({piso, puertas_abiertas}), int'({2'b11, 1'b1}));
    end
    chk("s4_final", int'({piso, busy}), int'({2'b11, 1'b0}));

    // 5: calls at both ends, up wins then reversal
    do_reset();
    for (int e = 0; e <= 40; e++) begin
      cycle((e == 0) ? 4'b1001 : 4'b0000);
      if (e == 1) chk("s5_up_first", int'(direccion), 1);
      if (e == 16) chk("s5_reverse", int'({piso, direccion}), int'({2'b11, 2'b10}));
      if (e == 27) chk("s5_bottom", int'({piso, puertas_abiertas}), int'({2'b00, 1'b1}));
    end
    chk("s5_final", int'({piso, direccion, busy}), int'({2'b00, 2'b00, 1'b0}));

    // 6: reset in the middle of a move
    do_reset();
    for (int e = 0; e <= 6; e++) cycle((e == 0) ? 4'b1000 : 4'b0000);
    chk("s6_mid_move", int'({piso, busy}), int'({2'b10, 1'b1}));
    do_reset();
    for (int e = 0; e < 20; e++) cycle(4'b0000);
    chk("s6_after", int'({piso, direccion, busy, pending}), int'({2'b01, 2'b00, 1'b0, 4'b0000}));

    // Randomised traffic with one reset in the middle
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) do_reset();
      c = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      cycle(c);
    end
    for (int i = 0; i < 150; i++) cycle(4'b0000);
    chk("drain_busy", int'({busy, pending}), 0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
